// File: rtl/pipe_mem_stage_pkg.sv
// Shared types and byte-lane constants for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int unsigned BE_W = 4;

    localparam logic [BE_W-1:0] BE_B0   = 4'b0001;
    localparam logic [BE_W-1:0] BE_B1   = 4'b0010;
    localparam logic [BE_W-1:0] BE_B2   = 4'b0100;
    localparam logic [BE_W-1:0] BE_B3   = 4'b1000;
    localparam logic [BE_W-1:0] BE_H0   = 4'b0011;
    localparam logic [BE_W-1:0] BE_H1   = 4'b1100;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Any lane pattern outside the byte/half/word set degrades to a full word.
    function automatic logic [BE_W-1:0] be_norm(input logic [BE_W-1:0] be);
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_WORD: be_norm = be;
            default:                                           be_norm = BE_WORD;
        endcase
    endfunction

    // Index of the lowest enabled lane of a normalised pattern.
    function automatic logic [1:0] be_lane(input logic [BE_W-1:0] be);
        case (be)
            BE_B1:        be_lane = 2'd1;
            BE_B2, BE_H1: be_lane = 2'd2;
            BE_B3:        be_lane = 2'd3;
            default:      be_lane = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_mem_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and memory.
interface pipe_mem_stage_if #(
    parameter int unsigned BITS = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [BITS-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [BITS-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [BITS-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/pipe_mem_stage_lane_align.sv
// Byte-lane steering: store data shifted up to its lane, load data extracted and zero-extended.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned BITS = 32
) (
    input  logic [BE_W-1:0] be_i,
    input  logic [BITS-1:0] st_data_i,
    input  logic [BITS-1:0] ld_word_i,
    output logic [BE_W-1:0] be_c,
    output logic [BITS-1:0] st_data_c,
    output logic [BITS-1:0] ld_data_c
);

    logic [4:0]      shamt;
    logic [BITS-1:0] ld_shift;

    always_comb begin
        be_c      = be_norm(be_i);
        shamt     = {be_lane(be_c), 3'b000};
        st_data_c = st_data_i << shamt;
        ld_shift  = ld_word_i >> shamt;
        ld_data_c = ld_shift;
        case (be_c)
            BE_B0, BE_B1, BE_B2, BE_B3: ld_data_c = BITS'(ld_shift[7:0]);
            BE_H0, BE_H1:               ld_data_c = BITS'(ld_shift[15:0]);
            default:                    ld_data_c = ld_shift;
        endcase
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM pipeline stage: data-memory access FSM, LL/SC reservation and the MEM/WB register.
module pipe_mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned BITS      = 32,
    parameter int unsigned REG_WORDS = 32,
    parameter int unsigned ADDR_LEFT = $clog2(REG_WORDS) - 1
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 sel_mem_s4,
    input  logic                 mem_rw_s4,
    input  logic                 atomic_s4,
    input  logic                 load_link_s4,
    input  logic                 check_link_s4,
    input  logic                 rw_s4,
    input  logic [ADDR_LEFT:0]   waddr_s4,
    input  logic [BITS-1:0]      alu_out_s4,
    input  logic [BITS-1:0]      r2_data_s4,
    input  logic [BE_W-1:0]      byte_en_s4,
    input  logic                 halt_s4,
    pipe_mem_stage_if.master     dmem,
    output logic                 stall_mem,
    output logic                 rw_s5,
    output logic [ADDR_LEFT:0]   waddr_s5,
    output logic [BITS-1:0]      wdata_s5,
    output logic                 halt_s5,
    output logic                 link_valid
);

    localparam int unsigned WA_W = BITS - 2;

    mem_state_t          state_q, state_d;
    logic                link_valid_q, link_valid_d;
    logic [WA_W-1:0]     link_addr_q, link_addr_d;
    logic                rw_s5_q, rw_s5_d;
    logic [ADDR_LEFT:0]  waddr_s5_q, waddr_s5_d;
    logic [BITS-1:0]     wdata_s5_q, wdata_s5_d;
    logic                halt_s5_q, halt_s5_d;

    logic [WA_W-1:0]     word_addr;
    logic                is_ll, is_sc, link_hit, sc_fail, mem_op;
    logic                req_c, stall_c;
    logic [BE_W-1:0]     be_c;
    logic [BITS-1:0]     st_data_c, ld_data_c;

    mem_lane_align #(.BITS(BITS)) u_align (
        .be_i      (byte_en_s4),
        .st_data_i (r2_data_s4),
        .ld_word_i (dmem.dmem_rdata),
        .be_c      (be_c),
        .st_data_c (st_data_c),
        .ld_data_c (ld_data_c)
    );

    // A failing SC never reaches memory; it resolves locally in one cycle.
    always_comb begin
        word_addr = alu_out_s4[BITS-1:2];
        is_ll     = atomic_s4 & load_link_s4 & mem_rw_s4;
        is_sc     = atomic_s4 & check_link_s4 & ~mem_rw_s4;
        link_hit  = link_valid_q & (link_addr_q == word_addr);
        sc_fail   = is_sc & ~link_hit;
        mem_op    = sel_mem_s4 & ~sc_fail;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        case (state_q)
            IDLE: begin
                req_c = mem_op;
                if (mem_op && !dmem.dmem_ack) state_d = WAIT;
            end
            WAIT: begin
                req_c = 1'b1;
                if (dmem.dmem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request is gated by reset so an in-flight access is withdrawn in the same cycle.
    assign stall_c          = dmem.dmem_req & ~dmem.dmem_ack;
    assign dmem.dmem_req    = rst_ & req_c;
    assign dmem.dmem_we     = ~mem_rw_s4;
    assign dmem.dmem_addr   = {word_addr, 2'b00};
    assign dmem.dmem_be     = be_c;
    assign dmem.dmem_wdata  = st_data_c;
    assign stall_mem        = stall_c;

    // MEM/WB register and reservation update; a stalled cycle inserts a bubble.
    always_comb begin
        rw_s5_d      = rw_s5_q;
        waddr_s5_d   = waddr_s5_q;
        wdata_s5_d   = wdata_s5_q;
        halt_s5_d    = halt_s5_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (stall_c) begin
            rw_s5_d   = 1'b0;
            halt_s5_d = 1'b0;
        end else begin
            rw_s5_d    = rw_s4;
            waddr_s5_d = waddr_s4;
            wdata_s5_d = alu_out_s4;
            halt_s5_d  = halt_s4;
            if (sel_mem_s4) begin
                if (mem_rw_s4) begin
                    wdata_s5_d = ld_data_c;
                    if (is_ll) begin
                        link_valid_d = 1'b1;
                        link_addr_d  = word_addr;
                    end
                end else if (is_sc) begin
                    rw_s5_d      = 1'b1;
                    wdata_s5_d   = {{(BITS-1){1'b0}}, ~sc_fail};
                    link_valid_d = 1'b0;
                end else begin
                    rw_s5_d = 1'b0;
                    if (link_addr_q == word_addr) link_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rw_s5_q      <= 1'b0;
            waddr_s5_q   <= '0;
            wdata_s5_q   <= '0;
            halt_s5_q    <= 1'b0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            rw_s5_q      <= rw_s5_d;
            waddr_s5_q   <= waddr_s5_d;
            wdata_s5_q   <= wdata_s5_d;
            halt_s5_q    <= halt_s5_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    assign rw_s5      = rw_s5_q;
    assign waddr_s5   = waddr_s5_q;
    assign wdata_s5   = wdata_s5_q;
    assign halt_s5    = halt_s5_q;
    assign link_valid = link_valid_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Self-checking bench for pipe_mem_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_pipe_mem_stage;

    typedef enum int {K_ALU, K_LD, K_ST, K_LL, K_SC} kind_e;

    typedef struct {
        kind_e       k;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [4:0]  wa;
        logic        rw;
        logic        halt;
    } ins_t;

    typedef struct {
        logic        req;
        int          stalls;
        logic        bub_ok;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        halt;
        logic        lv;
    } obs_t;

    typedef struct {
        logic        req;
        logic        rw;
        logic [31:0] wd;
        logic        lv;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_;
    logic sel_mem_s4, mem_rw_s4, atomic_s4, load_link_s4, check_link_s4, rw_s4, halt_s4;
    logic [4:0]  waddr_s4;
    logic [31:0] alu_out_s4, r2_data_s4;
    logic [3:0]  byte_en_s4;
    logic        stall_mem, rw_s5, halt_s5, link_valid;
    logic [4:0]  waddr_s5;
    logic [31:0] wdata_s5;

    int errors = 0;
    int checks = 0;

    pipe_mem_stage_if #(.BITS(32)) dmem ();

    pipe_mem_stage dut (
        .clk           (clk),
        .rst_          (rst_),
        .sel_mem_s4    (sel_mem_s4),
        .mem_rw_s4     (mem_rw_s4),
        .atomic_s4     (atomic_s4),
        .load_link_s4  (load_link_s4),
        .check_link_s4 (check_link_s4),
        .rw_s4         (rw_s4),
        .waddr_s4      (waddr_s4),
        .alu_out_s4    (alu_out_s4),
        .r2_data_s4    (r2_data_s4),
        .byte_en_s4    (byte_en_s4),
        .halt_s4       (halt_s4),
        .dmem          (dmem),
        .stall_mem     (stall_mem),
        .rw_s5         (rw_s5),
        .waddr_s5      (waddr_s5),
        .wdata_s5      (wdata_s5),
        .halt_s5       (halt_s5),
        .link_valid    (link_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(input int i);
        return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
    endfunction

    // Memory environment: acks after lat_cfg wait cycles, writes enabled lanes on the acked edge.
    int          lat_cfg = 0;
    int          cnt = 0;
    logic        busy = 1'b0;
    logic        mem_init_done = 1'b0;
    logic [31:0] env_mem [0:255];

    always @(negedge clk) begin
        if (dmem.dmem_req === 1'b1) begin
            if (busy ? (cnt == 0) : (lat_cfg == 0)) begin
                dmem.dmem_ack   <= 1'b1;
                dmem.dmem_rdata <= env_mem[dmem.dmem_addr[9:2]];
                busy            <= 1'b0;
            end else begin
                dmem.dmem_ack   <= 1'b0;
                dmem.dmem_rdata <= $urandom;
                busy            <= 1'b1;
                cnt             <= busy ? cnt - 1 : lat_cfg - 1;
            end
        end else begin
            dmem.dmem_ack <= 1'b0;
            busy          <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= seed_word(i);
            mem_init_done <= 1'b1;
        end else if (dmem.dmem_req === 1'b1 && dmem.dmem_we === 1'b1 && dmem.dmem_ack === 1'b1) begin
            for (int l = 0; l < 4; l++)
                if (dmem.dmem_be[l]) env_mem[dmem.dmem_addr[9:2]][8*l +: 8] <= dmem.dmem_wdata[8*l +: 8];
        end
    end

    // Reference model: word-addressed memory array plus the reservation as plain variables.
    logic [31:0] ref_mem [0:255];
    logic        m_lv;
    logic [29:0] m_la;

    function automatic logic [3:0] ref_be(input logic [3:0] b);
        if (b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}) return b;
        return 4'b1111;
    endfunction

    function automatic int low_lane(input logic [3:0] b);
        int lo = 0;
        for (int i = 3; i >= 0; i--) if (b[i]) lo = i;
        return lo;
    endfunction

    task automatic model_step(input ins_t i, output exp_t e);
        logic [3:0]  bn;
        logic [63:0] v;
        logic [63:0] sh;
        logic [7:0]  idx;
        logic        ok;
        int          lo, n;
        bn  = ref_be(i.be);
        lo  = low_lane(bn);
        n   = $countones(bn);
        idx = i.a[9:2];
        sh  = 64'(i.d) << (8 * lo);
        e.req = 1'b0; e.rw = i.rw; e.wd = i.a; e.be = bn; e.wdata = sh[31:0];
        case (i.k)
            K_ALU: ;
            K_LD, K_LL: begin
                e.req = 1'b1;
                v = (64'(ref_mem[idx]) >> (8 * lo)) & ((64'd1 << (8 * n)) - 64'd1);
                e.wd = v[31:0];
                if (i.k == K_LL) begin m_lv = 1'b1; m_la = i.a[31:2]; end
            end
            K_ST: begin
                e.req = 1'b1; e.rw = 1'b0;
                for (int l = 0; l < 4; l++) if (bn[l]) ref_mem[idx][8*l +: 8] = sh[8*l +: 8];
                if (m_la == i.a[31:2]) m_lv = 1'b0;
            end
            K_SC: begin
                ok = m_lv && (m_la == i.a[31:2]);
                e.req = ok; e.rw = 1'b1; e.wd = ok ? 32'd1 : 32'd0;
                if (ok) for (int l = 0; l < 4; l++) if (bn[l]) ref_mem[idx][8*l +: 8] = sh[8*l +: 8];
                m_lv = 1'b0;
            end
            default: ;
        endcase
        e.lv = m_lv;
    endtask

    function automatic ins_t mk(input kind_e k, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic [4:0] wa, input logic rw, input logic halt);
        ins_t i;
        i.k = k; i.a = a; i.d = d; i.be = be; i.wa = wa; i.rw = rw; i.halt = halt;
        return i;
    endfunction

    task automatic drive_s4(input ins_t i);
        sel_mem_s4    = (i.k != K_ALU);
        mem_rw_s4     = (i.k == K_LD) || (i.k == K_LL);
        atomic_s4     = (i.k == K_LL) || (i.k == K_SC);
        load_link_s4  = (i.k == K_LL);
        check_link_s4 = (i.k == K_SC);
        rw_s4         = i.rw;
        waddr_s4      = i.wa;
        alu_out_s4    = i.a;
        r2_data_s4    = i.d;
        byte_en_s4    = i.be;
        halt_s4       = i.halt;
    endtask

    task automatic drive_idle();
        drive_s4(mk(K_ALU, 32'h0, 32'h0, 4'b1111, 5'd0, 1'b0, 1'b0));
    endtask

    // Present one instruction (called at posedge+1) and run it to completion, recording what is seen.
    task automatic issue(input ins_t i, output obs_t o);
        logic st;
        logic done;
        drive_s4(i);
        o.req = 1'b0; o.stalls = 0; o.bub_ok = 1'b1; o.we = 1'b0; o.addr = '0; o.be = '0; o.wdata = '0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk); #1;
            if (dmem.dmem_req === 1'b1 && !o.req) begin
                o.req = 1'b1; o.we = dmem.dmem_we; o.addr = dmem.dmem_addr;
                o.be = dmem.dmem_be; o.wdata = dmem.dmem_wdata;
            end
            st = stall_mem;
            @(posedge clk); #1;
            if (st !== 1'b1) done = 1'b1;
            else begin
                o.stalls++;
                if (rw_s5 !== 1'b0 || halt_s5 !== 1'b0) o.bub_ok = 1'b0;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL issue_timeout: stall_mem still %b after 40 cycles, want 0", stall_mem);
        end
        o.rw = rw_s5; o.wa = waddr_s5; o.wd = wdata_s5; o.halt = halt_s5; o.lv = link_valid;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        m_lv = 1'b0; m_la = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
        drive_s4(mk(K_LD, 32'h100, 32'h0, 4'b1111, 5'd7, 1'b1, 1'b1));
        @(negedge clk); #1;
        checks++; if (dmem.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", dmem.dmem_req); end
        checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall_mem); end
        checks++; if (rw_s5 !== 1'b0) begin errors++; $display("FAIL rst_rw_s5: got %b want 0", rw_s5); end
        checks++; if (waddr_s5 !== 5'd0) begin errors++; $display("FAIL rst_waddr_s5: got %h want 0", waddr_s5); end
        checks++; if (wdata_s5 !== 32'd0) begin errors++; $display("FAIL rst_wdata_s5: got %h want 0", wdata_s5); end
        checks++; if (halt_s5 !== 1'b0) begin errors++; $display("FAIL rst_halt_s5: got %b want 0", halt_s5); end
        checks++; if (link_valid !== 1'b0) begin errors++; $display("FAIL rst_link: got %b want 0", link_valid); end
        drive_idle();
        rst_ = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        obs_t o; exp_t e; ins_t i;
        lat_cfg = 0;
        i = mk(K_ALU, 32'h1234, 32'h0, 4'b1111, 5'd5, 1'b1, 1'b0);
        model_step(i, e);
        issue(i, o);
        checks++; if (o.req !== 1'b0) begin errors++; $display("FAIL alu_req: got %b want 0", o.req); end
        checks++; if (o.rw !== 1'b1 || o.wa !== 5'd5) begin errors++; $display("FAIL alu_rw_wa: got %b/%0d want 1/5", o.rw, o.wa); end
        checks++; if (o.wd !== 32'h1234) begin errors++; $display("FAIL alu_wdata: got %h want 00001234", o.wd); end
    endtask

    task automatic test_load_wait();
        obs_t o; exp_t e; ins_t i;
        lat_cfg = 0;
        i = mk(K_ST, 32'h100, 32'hDEADBEEF, 4'b1111, 5'd0, 1'b0, 1'b0);
        model_step(i, e);
        issue(i, o);
        checks++; if (o.req !== 1'b1 || o.we !== 1'b1 || o.wdata !== 32'hDEADBEEF)
            begin errors++; $display("FAIL sw_issue: got req=%b we=%b wdata=%h want 1 1 deadbeef", o.req, o.we, o.wdata); end
        lat_cfg = 3;
        i = mk(K_LD, 32'h100, 32'h0, 4'b1111, 5'd9, 1'b1, 1'b0);
        model_step(i, e);
        issue(i, o);
        checks++; if (o.stalls != 3) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 3", o.stalls); end
        checks++; if (o.bub_ok !== 1'b1) begin errors++; $display("FAIL lw_bubble: got rw_s5/halt_s5 high during stall, want 0"); end
        checks++; if (o.addr !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h want 00000100", o.addr); end
        checks++; if (o.rw !== 1'b1 || o.wd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %b/%h want 1/deadbeef", o.rw, o.wd); end
    endtask

    task automatic test_lanes();
        obs_t o; exp_t e; ins_t i;
        lat_cfg = 0;
        i = mk(K_ST, 32'h300, 32'h11AA2233, 4'b1111, 5'd0, 1'b0, 1'b0);
        model_step(i, e); issue(i, o);
        i = mk(K_LD, 32'h302, 32'h0, 4'b0100, 5'd2, 1'b1, 1'b0);
        model_step(i, e); issue(i, o);
        checks++; if (o.wd !== 32'h000000AA) begin errors++; $display("FAIL lb_lane2: got %h want 000000aa", o.wd); end
        checks++; if (o.addr !== 32'h300) begin errors++; $display("FAIL lb_addr_align: got %h want 00000300", o.addr); end
        i = mk(K_ST, 32'h301, 32'h0000007F, 4'b0010, 5'd0, 1'b0, 1'b0);
        model_step(i, e); issue(i, o);
        checks++; if (o.wdata[15:8] !== 8'h7F || o.be !== 4'b0010)
            begin errors++; $display("FAIL sb_lane1: got wdata[15:8]=%h be=%b want 7f 0010", o.wdata[15:8], o.be); end
        i = mk(K_LD, 32'h300, 32'h0, 4'b1100, 5'd3, 1'b1, 1'b0);
        model_step(i, e); issue(i, o);
        checks++; if (o.wd !== 32'h000011AA) begin errors++; $display("FAIL lh_upper: got %h want 000011aa", o.wd); end
        i = mk(K_LD, 32'h300, 32'h0, 4'b0101, 5'd3, 1'b1, 1'b0);
        model_step(i, e); issue(i, o);
        checks++; if (o.wd !== 32'h11AA7F33 || o.be !== 4'b1111)
            begin errors++; $display("FAIL be_unsupported: got %h/%b want 11aa7f33/1111", o.wd, o.be); end
    endtask

    task automatic test_ll_sc();
        obs_t o; exp_t e; ins_t i;
        lat_cfg = 1;
        i = mk(K_LL, 32'h200, 32'h0, 4'b1111, 5'd3, 1'b1, 1'b0);
        model_step(i, e); issue(i, o);
        checks++; if (o.lv !== 1'b1) begin errors++; $display("FAIL ll_sets_link: got %b want 1", o.lv); end
        i = mk(K_SC, 32'h200, 32'd9, 4'b1111, 5'd4, 1'b1, 1'b0);
        model_step(i, e); issue(i, o);
        checks++; if (o.req !== 1'b1 || o.wdata !== 32'd9 || o.we !== 1'b1)
            begin errors++; $display("FAIL sc_store: got req=%b we=%b wdata=%h want 1 1 00000009", o.req, o.we, o.wdata); end
        checks++; if (o.rw !== 1'b1 || o.wd !== 32'd1 || o.lv !== 1'b0)
            begin errors++; $display("FAIL sc_pass: got rw=%b wd=%h link=%b want 1 1 0", o.rw, o.wd, o.lv); end
        i = mk(K_SC, 32'h200, 32'd10, 4'b1111, 5'd4, 1'b1, 1'b0);
        model_step(i, e); issue(i, o);
        checks++; if (o.req !== 1'b0 || o.stalls != 0)
            begin errors++; $display("FAIL sc_fail_noreq: got req=%b stalls=%0d want 0 0", o.req, o.stalls); end
        checks++; if (o.rw !== 1'b1 || o.wd !== 32'd0) begin errors++; $display("FAIL sc_fail_data: got %b/%h want 1/0", o.rw, o.wd); end
    endtask

    task automatic test_link_clear();
        obs_t o; exp_t e; ins_t i;
        logic [31:0] st_addr [2];
        logic [31:0] want [2];
        st_addr[0] = 32'h200; want[0] = 32'd0;
        st_addr[1] = 32'h204; want[1] = 32'd1;
        lat_cfg = 0;
        for (int t = 0; t < 2; t++) begin
            i = mk(K_LL, 32'h200, 32'h0, 4'b1111, 5'd3, 1'b1, 1'b0);
            model_step(i, e); issue(i, o);
            i = mk(K_ST, st_addr[t], 32'h55, 4'b1111, 5'd0, 1'b0, 1'b0);
            model_step(i, e); issue(i, o);
            i = mk(K_SC, 32'h200, 32'h66, 4'b1111, 5'd4, 1'b1, 1'b0);
            model_step(i, e); issue(i, o);
            checks++; if (o.wd !== want[t])
                begin errors++; $display("FAIL link_after_sw%0d: got %h want %h", t, o.wd, want[t]); end
        end
    endtask

    task automatic check_vs_model(input string tag, input obs_t o, input exp_t e, input ins_t i, input int lat);
        checks++; if (o.req !== e.req) begin errors++; $display("FAIL %s_req: got %b want %b", tag, o.req, e.req); end
        checks++; if (o.stalls != (e.req ? lat : 0)) begin errors++; $display("FAIL %s_stalls: got %0d want %0d", tag, o.stalls, e.req ? lat : 0); end
        checks++; if (o.bub_ok !== 1'b1) begin errors++; $display("FAIL %s_bubble: got write/halt during stall want none", tag); end
        checks++; if (o.rw !== e.rw || o.wa !== i.wa || o.halt !== i.halt)
            begin errors++; $display("FAIL %s_ctl: got rw=%b wa=%0d halt=%b want %b %0d %b", tag, o.rw, o.wa, o.halt, e.rw, i.wa, i.halt); end
        checks++; if (o.lv !== e.lv) begin errors++; $display("FAIL %s_link: got %b want %b", tag, o.lv, e.lv); end
        if (i.k != K_ST) begin
            checks++; if (o.wd !== e.wd) begin errors++; $display("FAIL %s_wdata: got %h want %h", tag, o.wd, e.wd); end
        end
        if (e.req) begin
            checks++; if (o.addr !== {i.a[31:2], 2'b00} || o.be !== e.be || o.we !== (i.k == K_ST || i.k == K_SC))
                begin errors++; $display("FAIL %s_bus: got a=%h be=%b we=%b want a=%h be=%b", tag, o.addr, o.be, o.we, {i.a[31:2], 2'b00}, e.be); end
            if (o.we) begin
                checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL %s_stdata: got %h want %h", tag, o.wdata, e.wdata); end
            end
        end
    endtask

    function automatic ins_t rand_ins(input bit mem_only_fast);
        logic [3:0] bes [8];
        ins_t i;
        int   r;
        bes[0] = 4'b0001; bes[1] = 4'b0010; bes[2] = 4'b0100; bes[3] = 4'b1000;
        bes[4] = 4'b0011; bes[5] = 4'b1100; bes[6] = 4'b1111; bes[7] = 4'b0110;
        r = mem_only_fast ? $urandom_range(0, 1) : $urandom_range(0, 9);
        i.a = 32'h200 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
        i.d = $urandom; i.be = bes[$urandom_range(0, 7)];
        i.wa = 5'($urandom); i.rw = 1'($urandom); i.halt = 1'($urandom_range(0, 7) == 0);
        case (r)
            0, 1, 2: i.k = K_LD;
            3, 4:    i.k = K_ST;
            5, 6:    begin i.k = K_ALU; i.a = $urandom; end
            7:       begin i.k = K_LL; i.be = 4'b1111; i.a = 32'h200 + 32'($urandom_range(0, 1)) * 4; end
            default: begin i.k = K_SC; i.be = 4'b1111; i.rw = 1'b1; i.a = 32'h200 + 32'($urandom_range(0, 1)) * 4; end
        endcase
        return i;
    endfunction

    task automatic test_back_to_back();
        obs_t o; exp_t e; ins_t i;
        lat_cfg = 0;
        for (int n = 0; n < 12; n++) begin
            i = rand_ins(1'b1);
            model_step(i, e); issue(i, o);
            check_vs_model("b2b", o, e, i, 0);
        end
    endtask

    task automatic test_random();
        obs_t o; exp_t e; ins_t i;
        for (int n = 0; n < 200; n++) begin
            lat_cfg = $urandom_range(0, 3);
            i = rand_ins(1'b0);
            model_step(i, e); issue(i, o);
            check_vs_model("rnd", o, e, i, lat_cfg);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; exp_t e; ins_t i;
        lat_cfg = 0;
        i = mk(K_LL, 32'h200, 32'h0, 4'b1111, 5'd3, 1'b1, 1'b0);
        model_step(i, e); issue(i, o);
        lat_cfg = 10;
        drive_s4(mk(K_LD, 32'h100, 32'h0, 4'b1111, 5'd8, 1'b1, 1'b0));
        @(negedge clk); @(negedge clk); #1;
        checks++; if (stall_mem !== 1'b1 || link_valid !== 1'b1)
            begin errors++; $display("FAIL pre_reset_wait: got stall=%b link=%b want 1 1", stall_mem, link_valid); end
        rst_ = 1'b0; #1;
        checks++; if (dmem.dmem_req !== 1'b0 || stall_mem !== 1'b0)
            begin errors++; $display("FAIL midrst_req: got req=%b stall=%b want 0 0", dmem.dmem_req, stall_mem); end
        checks++; if (link_valid !== 1'b0 || rw_s5 !== 1'b0)
            begin errors++; $display("FAIL midrst_state: got link=%b rw_s5=%b want 0 0", link_valid, rw_s5); end
        m_lv = 1'b0;
        drive_idle();
        @(negedge clk); #1;
        rst_ = 1'b1;
        @(posedge clk); #1;
        lat_cfg = 0;
        i = mk(K_ALU, 32'hCAFE0001, 32'h0, 4'b1111, 5'd11, 1'b1, 1'b0);
        model_step(i, e); issue(i, o);
        check_vs_model("postrst_alu", o, e, i, 0);
        lat_cfg = 2;
        i = mk(K_LD, 32'h100, 32'h0, 4'b1111, 5'd12, 1'b1, 1'b0);
        model_step(i, e); issue(i, o);
        check_vs_model("postrst_lw", o, e, i, 2);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_lanes();
        test_ll_sc();
        test_link_clear();
        test_back_to_back();
        test_random();
        test_reset_mid();
        drive_idle();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
